// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller: forwarding selects,
// MEM-stage handshake states and the hard-wired zero register.
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  typedef enum logic [1:0] {
    RUN  = 2'b00,
    WAIT = 2'b01,
    ERR  = 2'b10
  } mem_state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // True when a producer register is non-zero and names the consumer register.
  function automatic logic reg_match(input logic [4:0] dst, input logic [4:0] src);
    return (dst != REG_ZERO) && (dst == src);
  endfunction

endpackage

// File: rtl/hazard_ctrl_fwd_select.sv
// Forwarding source select for one EX operand; the MEM-stage result beats WB.
module fwd_select
  import hazard_pkg::*;
(
  input  logic [4:0] src,
  input  logic [4:0] WriteReg_M,
  input  logic [4:0] WriteReg_W,
  input  logic       RegWrite_M,
  input  logic       RegWrite_W,
  output fwd_sel_t   sel
);

  // Priority select: newest producer first.
  always_comb begin
    sel = FWD_RF;
    if (RegWrite_M && reg_match(WriteReg_M, src))      sel = FWD_MEM;
    else if (RegWrite_W && reg_match(WriteReg_W, src)) sel = FWD_WB;
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage core: stalls, flushes,
// forwarding selects and the data-memory handshake with timeout.
// Optional perf counters (cnt_lw, cnt_br, cnt_mem) under `HAZ_PERF_CNT_EN.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 255
`ifdef HAZ_PERF_CNT_EN
  ,
  parameter int unsigned CNT_W = 32
`endif
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] RsD,
  input  logic [4:0] RtD,
  input  logic [4:0] RsE,
  input  logic [4:0] RtE,
  input  logic [4:0] WriteReg_E,
  input  logic [4:0] WriteReg_M,
  input  logic [4:0] WriteReg_W,
  input  logic       RegWrite_E,
  input  logic       RegWrite_M,
  input  logic       RegWrite_W,
  input  logic       MemToReg_E,
  input  logic       MemToReg_M,
  input  logic       BranchD,
  input  logic       RedirectD,
  input  logic       mem_req_M,
  input  logic       dmem_ack,
  output logic       dmem_req,
  output logic       StallF,
  output logic       StallD,
  output logic       StallE,
  output logic       StallM,
  output logic       FlushD,
  output logic       FlushE,
  output logic       FlushW,
  output logic [1:0] ForwardAE,
  output logic [1:0] ForwardBE,
  output logic       ForwardAD,
  output logic       ForwardBD,
  output logic       mem_err
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] cnt_lw,
  output logic [CNT_W-1:0] cnt_br,
  output logic [CNT_W-1:0] cnt_mem
`endif
);

  localparam int unsigned TW = $clog2(MEM_TIMEOUT);
  localparam logic [TW-1:0] TIMER_LAST = TW'(MEM_TIMEOUT - 1);

  mem_state_t    state, state_nxt;
  logic [TW-1:0] timer, timer_nxt;
  logic          req_fsm, stall_fsm, err_fsm;
  logic          memstall, lwstall, brstall;
  fwd_sel_t      sel_a, sel_b;

  fwd_select u_fwd_a (
    .src        (RsE),
    .WriteReg_M (WriteReg_M),
    .WriteReg_W (WriteReg_W),
    .RegWrite_M (RegWrite_M),
    .RegWrite_W (RegWrite_W),
    .sel        (sel_a)
  );

  fwd_select u_fwd_b (
    .src        (RtE),
    .WriteReg_M (WriteReg_M),
    .WriteReg_W (WriteReg_W),
    .RegWrite_M (RegWrite_M),
    .RegWrite_W (RegWrite_W),
    .sel        (sel_b)
  );

  // ID branch-compare forwarding and load-use / branch data hazards.
  always_comb begin
    ForwardAE = sel_a;
    ForwardBE = sel_b;
    ForwardAD = RegWrite_M && reg_match(RsD, WriteReg_M);
    ForwardBD = RegWrite_M && reg_match(RtD, WriteReg_M);
    lwstall   = MemToReg_E && (RtE != REG_ZERO) && ((RtE == RsD) || (RtE == RtD));
    brstall   = BranchD &&
                ((RegWrite_E && (reg_match(WriteReg_E, RsD) || reg_match(WriteReg_E, RtD))) ||
                 (MemToReg_M && (reg_match(WriteReg_M, RsD) || reg_match(WriteReg_M, RtD))));
  end

  // Handshake state and timeout counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
      timer <= '0;
    end else begin
      state <= state_nxt;
      timer <= timer_nxt;
    end
  end

  // Handshake next-state and per-state request/stall/error terms.
  // The ack cycle in WAIT does not stall: the access completes and M must
  // advance, otherwise the held load would re-request in RUN.
  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    req_fsm   = 1'b0;
    stall_fsm = 1'b0;
    err_fsm   = 1'b0;
    case (state)
      RUN: begin
        req_fsm   = mem_req_M;
        stall_fsm = mem_req_M && !dmem_ack;
        if (mem_req_M && !dmem_ack) begin
          state_nxt = WAIT;
          timer_nxt = '0;
        end
      end
      WAIT: begin
        req_fsm   = 1'b1;
        stall_fsm = !dmem_ack;
        if (dmem_ack)                 state_nxt = RUN;
        else if (timer == TIMER_LAST) state_nxt = ERR;
        else                          timer_nxt = timer + TW'(1);
      end
      ERR: begin
        err_fsm = 1'b1;
      end
      default: state_nxt = RUN;
    endcase
  end

  // Pipeline control; FSM-derived terms are forced low while reset is held.
  always_comb begin
    dmem_req = rst_n && req_fsm;
    memstall = rst_n && stall_fsm;
    mem_err  = rst_n && err_fsm;
    StallF   = lwstall || brstall || memstall || mem_err;
    StallD   = StallF;
    StallE   = memstall || mem_err;
    StallM   = StallE;
    FlushW   = memstall;
    FlushE   = (lwstall || brstall) && !memstall && !mem_err;
    FlushD   = RedirectD && !StallD;
  end

`ifdef HAZ_PERF_CNT_EN
  // Saturating stall-cycle counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_lw  <= '0;
      cnt_br  <= '0;
      cnt_mem <= '0;
    end else begin
      if (lwstall  && (cnt_lw  != '1)) cnt_lw  <= cnt_lw  + CNT_W'(1);
      if (brstall  && (cnt_br  != '1)) cnt_br  <= cnt_br  + CNT_W'(1);
      if (memstall && (cnt_mem != '1)) cnt_mem <= cnt_mem + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed-vector bench for hazard_ctrl (MEM_TIMEOUT=4).
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] RsD, RtD, RsE, RtE, WriteReg_E, WriteReg_M, WriteReg_W;
  logic       RegWrite_E, RegWrite_M, RegWrite_W, MemToReg_E, MemToReg_M;
  logic       BranchD, RedirectD, mem_req_M, dmem_ack;
  logic       dmem_req, StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW;
  logic [1:0] ForwardAE, ForwardBE;
  logic       ForwardAD, ForwardBD, mem_err;
`ifdef HAZ_PERF_CNT_EN
  logic [31:0] cnt_lw, cnt_br, cnt_mem;
`endif

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.MEM_TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE),
    .WriteReg_E(WriteReg_E), .WriteReg_M(WriteReg_M), .WriteReg_W(WriteReg_W),
    .RegWrite_E(RegWrite_E), .RegWrite_M(RegWrite_M), .RegWrite_W(RegWrite_W),
    .MemToReg_E(MemToReg_E), .MemToReg_M(MemToReg_M),
    .BranchD(BranchD), .RedirectD(RedirectD),
    .mem_req_M(mem_req_M), .dmem_ack(dmem_ack), .dmem_req(dmem_req),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .ForwardAD(ForwardAD), .ForwardBD(ForwardBD), .mem_err(mem_err)
`ifdef HAZ_PERF_CNT_EN
    , .cnt_lw(cnt_lw), .cnt_br(cnt_br), .cnt_mem(cnt_mem)
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clr();
    RsD = 0; RtD = 0; RsE = 0; RtE = 0;
    WriteReg_E = 0; WriteReg_M = 0; WriteReg_W = 0;
    RegWrite_E = 0; RegWrite_M = 0; RegWrite_W = 0;
    MemToReg_E = 0; MemToReg_M = 0;
    BranchD = 0; RedirectD = 0; mem_req_M = 0; dmem_ack = 0;
  endtask

  // Advance one clock; inputs change and checks happen away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int unsigned nreq, nstall, nflw;
    clr();
    rst_n = 1'b0;
    mem_req_M = 1'b1;
    #2;
    check_eq("rst_dmem_req", dmem_req, 0);
    check_eq("rst_StallM", StallM, 0);
    check_eq("rst_mem_err", mem_err, 0);
    check_eq("rst_FlushW", FlushW, 0);
    clr();
    tick();
    rst_n = 1'b1;
    tick();

    // 1: forwarding priority and $0 exclusion
    RegWrite_M = 1; WriteReg_M = 3; RegWrite_W = 1; WriteReg_W = 3; RsE = 3; RtE = 3;
    #2;
    check_eq("fwd_AE_mem", ForwardAE, 2'b10);
    check_eq("fwd_BE_mem", ForwardBE, 2'b10);
    RegWrite_M = 0; #2;
    check_eq("fwd_AE_wb", ForwardAE, 2'b01);
    RegWrite_M = 1; WriteReg_M = 0; RsE = 0; #2;
    check_eq("fwd_AE_zero", ForwardAE, 2'b00);
    check_eq("fwd_BE_wb", ForwardBE, 2'b01);
    clr(); tick();

    // 2: load-use stall
    MemToReg_E = 1; RegWrite_E = 1; WriteReg_E = 5; RtE = 5; RsD = 5; #2;
    check_eq("lw_StallF", StallF, 1);
    check_eq("lw_StallD", StallD, 1);
    check_eq("lw_FlushE", FlushE, 1);
    check_eq("lw_StallE", StallE, 0);
    tick();
    clr(); MemToReg_M = 1; RegWrite_M = 1; WriteReg_M = 5; RsE = 5; #2;
    check_eq("lw_next_StallF", StallF, 0);
    check_eq("lw_next_fwdAE", ForwardAE, 2'b10);
    clr(); MemToReg_E = 1; RtE = 0; RtD = 0; #2;
    check_eq("lw_zero_StallF", StallF, 0);
    check_eq("lw_zero_FlushE", FlushE, 0);
    clr(); tick();

    // 3: branch operand produced in EX, then forwarded from M
    BranchD = 1; RsD = 4; RegWrite_E = 1; WriteReg_E = 4; #2;
    check_eq("br_StallD", StallD, 1);
    check_eq("br_FlushE", FlushE, 1);
    check_eq("br_ForwardAD0", ForwardAD, 0);
    tick();
    RegWrite_E = 0; WriteReg_E = 0; RegWrite_M = 1; WriteReg_M = 4; #2;
    check_eq("br_next_StallD", StallD, 0);
    check_eq("br_ForwardAD1", ForwardAD, 1);
    clr(); BranchD = 1; RtD = 7; MemToReg_M = 1; RegWrite_M = 1; WriteReg_M = 7; #2;
    check_eq("br_lwM_StallF", StallF, 1);
    check_eq("br_lwM_ForwardBD", ForwardBD, 1);
    clr(); tick();

    // 4: ack after 3 cycles; zero-wait access
    nreq = 0; nstall = 0; nflw = 0;
    mem_req_M = 1;
    for (int i = 0; i < 5; i++) begin
      dmem_ack = (i == 3);
      if (i == 4) mem_req_M = 0;
      #2;
      nreq += dmem_req; nstall += StallM; nflw += FlushW;
      if (i == 0) check_eq("mem_c0_StallF", StallF, 1);
      if (i == 3) check_eq("mem_ack_StallE", StallE, 0);
      tick();
    end
    check_eq("mem_req_cycles", nreq, 4);
    check_eq("mem_stall_cycles", nstall, 3);
    check_eq("mem_flushw_cycles", nflw, 3);
    mem_req_M = 1; dmem_ack = 1; #2;
    check_eq("zw_dmem_req", dmem_req, 1);
    check_eq("zw_StallM", StallM, 0);
    tick();
    mem_req_M = 0; dmem_ack = 0; #2;
    check_eq("zw_after_req", dmem_req, 0);
    clr(); tick();

    // 6: redirect held off during memory stall
    RedirectD = 1; mem_req_M = 1; #2;
    check_eq("rd_c0_FlushD", FlushD, 0);
    tick(); #2;
    check_eq("rd_c1_FlushD", FlushD, 0);
    tick(); dmem_ack = 1; #2;
    check_eq("rd_c2_FlushD", FlushD, 1);
    tick(); clr(); #2;
    check_eq("rd_c3_FlushD", FlushD, 0);
    tick();

    // Reset mid-WAIT drops the request asynchronously
    mem_req_M = 1; tick(); #2;
    check_eq("abort_wait_req", dmem_req, 1);
    rst_n = 0; #1;
    check_eq("abort_rst_req", dmem_req, 0);
    clr(); tick(); rst_n = 1; tick();

    // 5: timeout after 4 WAIT cycles, sticky until reset
    mem_req_M = 1;
    for (int i = 0; i < 5; i++) begin
      #2;
      check_eq("to_wait_req", dmem_req, 1);
      check_eq("to_wait_err", mem_err, 0);
      tick();
    end
    MemToReg_E = 1; RtE = 2; RsD = 2; #2;
    check_eq("to_err", mem_err, 1);
    check_eq("to_err_req", dmem_req, 0);
    check_eq("to_err_StallM", StallM, 1);
    check_eq("to_err_StallF", StallF, 1);
    check_eq("to_err_FlushE", FlushE, 0);
    check_eq("to_err_FlushW", FlushW, 0);
    clr(); tick(); tick(); #2;
    check_eq("to_err_sticky", mem_err, 1);
    rst_n = 0; #1;
    check_eq("to_rst_err", mem_err, 0);
    tick(); rst_n = 1; tick();
    mem_req_M = 1; dmem_ack = 1; #2;
    check_eq("to_run_req", dmem_req, 1);
    check_eq("to_run_StallM", StallM, 0);
    check_eq("to_run_err", mem_err, 0);
    clr(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
